// File: rtl/ad9914_pkg.sv
// rtl/ad9914_pkg.sv - register map, masks and state types for the AD9914 sweep sequencer
package ad9914_pkg;

  localparam logic [7:0]  REG_CFR2  = 8'h01;
  localparam logic [7:0]  REG_LOWER = 8'h04;
  localparam logic [7:0]  REG_UPPER = 8'h05;
  localparam logic [7:0]  REG_PSTEP = 8'h06;
  localparam logic [7:0]  REG_NSTEP = 8'h07;
  localparam logic [7:0]  REG_RATE  = 8'h08;
  localparam logic [7:0]  REG_PROF0 = 8'h0C;
  localparam logic [31:0] DRG_EN    = 32'h0008_0000;
  localparam int          NUM_FIELDS = 6;

  typedef enum logic [2:0] {
    FLD_LOWER = 3'd0,
    FLD_UPPER = 3'd1,
    FLD_PSTEP = 3'd2,
    FLD_NSTEP = 3'd3,
    FLD_RATE  = 3'd4,
    FLD_DWELL = 3'd5
  } field_e;

  typedef enum logic [1:0] {S_IDLE, S_PROG, S_ARM, S_DWELL} state_e;

  // Writer handshake phases: wait idle, hold load until accepted, wait completion
  typedef enum logic [1:0] {WP_FIN, WP_LOAD, WP_DONE} wphase_e;

  // Ramp fields occupy consecutive registers starting at LOWER
  function automatic logic [7:0] field_addr(field_e f);
    return REG_LOWER + {5'd0, f};
  endfunction

endpackage

// File: rtl/ad9914_sweep_seq_if.sv
// rtl/ad9914_sweep_seq_if.sv - handshake bundle between the sequencer and ad9914_reg_wr
interface ad9914_sweep_seq_if;
  logic        wr_load;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_nbytes;
  logic        wr_busy;
  logic        wr_finish;

  modport master (output wr_load, wr_addr, wr_data, wr_nbytes, input wr_busy, wr_finish);
  modport slave  (input wr_load, wr_addr, wr_data, wr_nbytes, output wr_busy, wr_finish);
endinterface

// File: rtl/ad9914_seg_table.sv
// rtl/ad9914_seg_table.sv - NUM_SEG x 6 x 32 segment register file, one write and one row read port
module ad9914_seg_table
  import ad9914_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int SEG_W   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [SEG_W-1:0]                 wseg,
  input  logic [2:0]                       wfield,
  input  logic [31:0]                      wdata,
  input  logic [SEG_W-1:0]                 rseg,
  output logic [NUM_FIELDS-1:0][31:0]      rrow
);

  localparam logic [SEG_W:0] NSEG = (SEG_W+1)'(NUM_SEG);

  logic [NUM_FIELDS-1:0][31:0] mem [NUM_SEG];

  // Table write; out-of-range segment or field indices are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SEG; s++) mem[s] <= '0;
    end else if (we && ({1'b0, wseg} < NSEG) && (wfield < 3'(NUM_FIELDS))) begin
      mem[wseg][wfield] <= wdata;
    end
  end

  // Whole-row combinational read
  always_comb begin
    rrow = '0;
    if ({1'b0, rseg} < NSEG) rrow = mem[rseg];
  end

endmodule

// File: rtl/ad9914_sweep_seq.sv
// rtl/ad9914_sweep_seq.sv - multi-segment DRG sweep sequencer driving ad9914_reg_wr
module ad9914_sweep_seq
  import ad9914_pkg::*;
#(
  parameter int          NUM_SEG       = 4,
  parameter int          PRE_TRIG_LEAD = 40,
  parameter int          WR_TIMEOUT    = 4096,
  parameter logic [31:0] CFR2_BASE     = 32'h0000_191C,
  localparam int         SEG_W         = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_seg,
  input  logic [2:0]       cfg_field,
  input  logic [31:0]      cfg_data,
  input  logic [SEG_W-1:0] seg_count,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [SEG_W-1:0] seg_idx,
  output logic             pre_trig,
  output logic             trig,
  output logic             osk,
  input  logic             dover,
  output logic             dctrl,
  ad9914_sweep_seq_if.master wr
);

  localparam int             TMO_W = $clog2(WR_TIMEOUT + 1);
  localparam logic [SEG_W:0] NSEG  = (SEG_W+1)'(NUM_SEG);
  localparam logic [31:0]    LEAD  = 32'(PRE_TRIG_LEAD);

  state_e  state_q, state_d;
  wphase_e wph_q, wph_d;
  field_e  field_q, field_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [31:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NUM_FIELDS-1:0][31:0] cur_q, rrow;
  logic wr_load_q, wr_load_d, dctrl_q, dctrl_d, done_q, done_d, error_q, error_d, dover_q;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic [SEG_W-1:0] last_seg;
  logic [31:0] dwell, thr;
  logic fixed, hs_ok;

  ad9914_seg_table #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) u_table (
    .clk(clk), .rst(rst), .we(cfg_we), .wseg(cfg_seg), .wfield(cfg_field),
    .wdata(cfg_data), .rseg(seg_d), .rrow(rrow)
  );

  assign last_seg = ({1'b0, seg_count} >= NSEG) ? SEG_W'(NUM_SEG - 1) : seg_count;
  assign fixed    = (cur_q[FLD_PSTEP] == 32'd0);
  assign dwell    = cur_q[FLD_DWELL];
  assign thr      = (dwell > LEAD) ? dwell - LEAD : 32'd0;
  assign hs_ok    = (wph_q == WP_LOAD) ? wr.wr_busy : wr.wr_finish;

  // Next-state logic for the sequencer and its embedded writer handshake
  always_comb begin
    state_d   = state_q;
    wph_d     = wph_q;
    field_d   = field_q;
    seg_d     = seg_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    wr_load_d = wr_load_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dctrl_d   = dctrl_q;
    error_d   = error_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PROG;
          seg_d   = '0;
          error_d = 1'b0;
          field_d = FLD_LOWER;
          wph_d   = WP_FIN;
          tmo_d   = '0;
        end
      end
      S_PROG, S_ARM: begin
        if (stop || (!hs_ok && tmo_q == TMO_W'(WR_TIMEOUT))) begin
          // Abort; a transfer already accepted by the writer finishes on its own
          error_d   = error_q | ~stop;
          state_d   = S_IDLE;
          wr_load_d = 1'b0;
          dctrl_d   = 1'b0;
          done_d    = 1'b1;
        end else if (!hs_ok) begin
          tmo_d = tmo_q + 1'b1;
        end else begin
          tmo_d = '0;
          case (wph_q)
            WP_FIN: begin
              wr_load_d = 1'b1;
              wph_d     = WP_LOAD;
              if (state_q == S_PROG) begin
                wr_addr_d = field_addr(field_q);
                wr_data_d = cur_q[field_q];
              end else begin
                // Fixed-frequency segments rewrite CFR2 with the DRG left disabled
                wr_addr_d = REG_CFR2;
                wr_data_d = fixed ? CFR2_BASE : (CFR2_BASE | DRG_EN);
                dctrl_d   = ~fixed;
              end
            end
            WP_LOAD: begin
              wr_load_d = 1'b0;
              wph_d     = WP_FIN;
              if (state_q == S_ARM) wph_d = WP_DONE;
              else if (field_q == FLD_RATE) state_d = S_ARM;
              else field_d = field_e'(field_q + 3'd1);
            end
            default: begin
              dctrl_d = 1'b0;
              cnt_d   = '0;
              wph_d   = WP_FIN;
              state_d = S_DWELL;
            end
          endcase
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
          dctrl_d = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == dwell) begin
          dctrl_d = 1'b0;
          field_d = FLD_LOWER;
          wph_d   = WP_FIN;
          tmo_d   = '0;
          state_d = S_PROG;
          if (seg_q < last_seg) begin
            seg_d = seg_q + 1'b1;
          end else if (loop_en) begin
            seg_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
          // Triangle ramps reverse direction on every DRG-over rising edge
          if (cur_q[FLD_NSTEP] != 32'd0 && dover && !dover_q) dctrl_d = ~dctrl_q;
        end
      end
    endcase
  end

  // State register; the segment row is captured as PROG is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wph_q     <= WP_FIN;
      field_q   <= FLD_LOWER;
      seg_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      cur_q     <= '0;
      wr_load_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dctrl_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      dover_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wph_q     <= wph_d;
      field_q   <= field_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      wr_load_q <= wr_load_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dctrl_q   <= dctrl_d;
      done_q    <= done_d;
      error_q   <= error_d;
      dover_q   <= dover;
      if (state_d == S_PROG && state_q != S_PROG) cur_q <= rrow;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign seg_idx      = seg_q;
  assign dctrl        = dctrl_q;
  assign pre_trig     = (state_q == S_DWELL) && (cnt_q >= thr) && (cnt_q < dwell);
  assign osk          = (state_q == S_DWELL) && (!dover || fixed);
  assign trig         = osk;
  assign wr.wr_load   = wr_load_q;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_data   = wr_data_q;
  assign wr.wr_nbytes = 4'd4;

endmodule
